// File: rtl/dma_block_copier.sv
// Block copier: moves len bytes from src to dst through a 4-byte FIFO, alternating
// read bursts of up to 4 bytes with the matching write bursts on one DMA port.
module dma_block_copier (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [21:0] src_addr,
  input  logic [21:0] dst_addr,
  input  logic [15:0] len,
  output logic        busy,
  output logic        done,
  output logic        aborted,
  output logic        dma_req,
  output logic [21:0] dma_addr,
  output logic        dma_rnw,
  output logic [7:0]  dma_wd,
  input  logic        dma_ack,
  input  logic        dma_end,
  input  logic [7:0]  dma_rd
);

  typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2} state_e;

  state_e      state_q, state_d;
  logic [21:0] src_q, src_d, dst_q, dst_d;
  logic [15:0] rd_left_q, rd_left_d, wr_left_q, wr_left_d;
  logic [2:0]  phase_q, phase_d;
  logic [2:0]  out_q, out_d;
  logic        abort_q, abort_d;
  logic [7:0]  fifo_q [4];
  logic [1:0]  wp_q, rp_q;
  logic [2:0]  cnt_q, cnt_d;
  logic        acc, ended, push, pop, flush;

  assign busy     = (state_q != IDLE);
  assign dma_rnw  = (state_q != WR);
  assign dma_addr = (state_q == WR) ? dst_q : src_q;
  assign dma_wd   = fifo_q[rp_q];
  // abort_q gates requests, so a request presented in the abort cycle itself can still be acked
  assign dma_req  = ~abort_q &
                    (((state_q == RD) & (phase_q < 3'd4) & (rd_left_q != 16'd0)) |
                     ((state_q == WR) & (cnt_q != 3'd0)));

  always_comb begin
    acc   = dma_req & dma_ack;
    ended = dma_end & (out_q != 3'd0);
    push  = ended & (state_q == RD);
    pop   = acc & (state_q == WR);
    out_d = out_q + {2'b00, acc} - {2'b00, ended};
    cnt_d = cnt_q + {2'b00, push} - {2'b00, pop};
  end

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    rd_left_d = rd_left_q;
    wr_left_d = wr_left_q;
    phase_d   = phase_q;
    abort_d   = abort_q;
    flush     = 1'b0;
    done      = 1'b0;
    aborted   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          src_d     = src_addr;
          dst_d     = dst_addr;
          rd_left_d = len;
          wr_left_d = len;
          phase_d   = '0;
          abort_d   = 1'b0;
          // an empty copy passes straight through WR, which exits with done at once
          state_d   = (len == 16'd0) ? WR : RD;
        end
      end
      RD: begin
        if (acc) begin
          src_d     = src_q + 22'd1;
          rd_left_d = rd_left_q - 16'd1;
          phase_d   = phase_q + 3'd1;
        end
        if (abort) abort_d = 1'b1;
        if (abort_q) begin
          if (out_q == 3'd0) begin
            state_d = IDLE;
            flush   = 1'b1;
            aborted = 1'b1;
            abort_d = 1'b0;
          end
        end else if (((phase_d == 3'd4) || (rd_left_d == 16'd0)) && (out_d == 3'd0)) begin
          state_d = WR;
        end
      end
      WR: begin
        if (acc) begin
          dst_d     = dst_q + 22'd1;
          wr_left_d = wr_left_q - 16'd1;
        end
        if (abort) abort_d = 1'b1;
        if (abort_q) begin
          if (out_q == 3'd0) begin
            state_d = IDLE;
            flush   = 1'b1;
            aborted = 1'b1;
            abort_d = 1'b0;
          end
        end else if ((cnt_d == 3'd0) && (out_d == 3'd0)) begin
          if (wr_left_d != 16'd0) begin
            state_d = RD;
            phase_d = '0;
          end else begin
            state_d = IDLE;
            done    = 1'b1;
            abort_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      rd_left_q <= '0;
      wr_left_q <= '0;
      phase_q   <= '0;
      out_q     <= '0;
      abort_q   <= 1'b0;
      wp_q      <= '0;
      rp_q      <= '0;
      cnt_q     <= '0;
      for (int unsigned i = 0; i < 4; i++) fifo_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      rd_left_q <= rd_left_d;
      wr_left_q <= wr_left_d;
      phase_q   <= phase_d;
      out_q     <= out_d;
      abort_q   <= abort_d;
      if (flush) begin
        wp_q  <= '0;
        rp_q  <= '0;
        cnt_q <= '0;
      end else begin
        if (push) begin
          fifo_q[wp_q] <= dma_rd;
          wp_q         <= wp_q + 2'd1;
        end
        if (pop) rp_q <= rp_q + 2'd1;
        cnt_q <= cnt_d;
      end
    end
  end

endmodule

// File: tb/tb_dma_block_copier.sv
// Bench for dma_block_copier: DMA port responder with configurable ack/end latency
// and a scoreboard of expected requests built from each start's parameters.
module tb_dma_block_copier;

  logic        clk = 1'b0;
  logic        rst_n, start, abort;
  logic [21:0] src_addr, dst_addr;
  logic [15:0] len;
  logic        busy, done, aborted, dma_req, dma_rnw;
  logic [21:0] dma_addr;
  logic [7:0]  dma_wd, dma_rd;
  logic        dma_ack, dma_end;

  dma_block_copier dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
    .busy(busy), .done(done), .aborted(aborted),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_rnw(dma_rnw), .dma_wd(dma_wd),
    .dma_ack(dma_ack), .dma_end(dma_end), .dma_rd(dma_rd)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic rnw; logic [21:0] addr; logic [7:0] wd; } exp_t;
  typedef struct packed { logic rnw; logic [21:0] addr; int due; } pend_t;

  exp_t  exp_q [$];
  pend_t pend [$];

  int checks = 0, errors = 0;
  int cyc = 0, hold = 0, ack_delay = 1, end_lat = 2;
  int done_cnt = 0, abort_cnt = 0, busy_cyc = 0, req_cyc = 0, end_cnt = 0, ends_at_abort = 0;

  function automatic logic [7:0] fmem(input logic [21:0] a);
    return a[7:0] ^ {a[13:8], 2'b01} ^ a[21:14] ^ 8'hA5;
  endfunction

  function automatic int pend_wr();
    int n = 0;
    foreach (pend[i]) if (!pend[i].rnw) n++;
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic push_copy(input logic [21:0] s, input logic [21:0] d, input logic [15:0] n);
    logic [21:0] sp, dp;
    int rem, k;
    sp = s; dp = d; rem = int'(n);
    while (rem > 0) begin
      k = (rem > 4) ? 4 : rem;
      for (int i = 0; i < k; i++) exp_q.push_back('{rnw: 1'b1, addr: sp + 22'(i), wd: 8'h00});
      for (int i = 0; i < k; i++) exp_q.push_back('{rnw: 1'b0, addr: dp + 22'(i), wd: fmem(sp + 22'(i))});
      sp = sp + 22'(k); dp = dp + 22'(k); rem = rem - k;
    end
  endtask

  task automatic pulse_start(input logic [21:0] s, input logic [21:0] d, input logic [15:0] n);
    src_addr = s; dst_addr = d; len = n; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_end(input int d0, input int a0, input string tag);
    logic seen = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      tick();
      if (done_cnt != d0 || abort_cnt != a0) begin seen = 1'b1; break; end
    end
    chk({tag, "_finished"}, 32'(seen), 32'd1);
    tick();
  endtask

  task automatic run_copy(input logic [21:0] s, input logic [21:0] d, input logic [15:0] n,
                          input string tag);
    int d0, a0;
    d0 = done_cnt; a0 = abort_cnt;
    push_copy(s, d, n);
    pulse_start(s, d, n);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    wait_end(d0, a0, tag);
    chk({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
    chk({tag, "_aborted_pulses"}, 32'(abort_cnt - a0), 32'd0);
    chk({tag, "_all_issued"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  // DMA sequencer model: decides ack/end at each falling edge, then samples the status outputs.
  initial begin : responder
    exp_t e;
    dma_ack = 1'b0; dma_end = 1'b0; dma_rd = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (dma_end && pend.size() > 0) void'(pend.pop_front());
      dma_end = 1'b0; dma_rd = '0;
      if (pend.size() > 0 && pend[0].due <= cyc + 1) begin
        dma_end = 1'b1;
        end_cnt++;
        if (pend[0].rnw) dma_rd = fmem(pend[0].addr);
      end
      dma_ack = 1'b0;
      if (dma_req) begin
        if (exp_q.size() == 0) begin
          chk("req_unexpected", 32'(dma_req), 32'd0);
        end else begin
          e = exp_q[0];
          chk("req_rnw", 32'(dma_rnw), 32'(e.rnw));
          chk("req_addr", 32'(dma_addr), 32'(e.addr));
          if (!e.rnw) chk("req_wd", 32'(dma_wd), 32'(e.wd));
          if (hold >= ack_delay) begin
            dma_ack = 1'b1;
            hold = 0;
            void'(exp_q.pop_front());
            pend.push_back('{rnw: dma_rnw, addr: dma_addr, due: cyc + 1 + end_lat});
          end else begin
            hold++;
          end
        end
      end else begin
        hold = 0;
      end
      #1;
      if (done) done_cnt++;
      if (aborted) begin abort_cnt++; ends_at_abort = end_cnt; end
      if (busy) busy_cyc++;
      if (dma_req) req_cyc++;
    end
  end

  initial begin : watchdog
    #500000;
    errors++;
    $display("FAIL watchdog simulation did not finish observed=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int d0, a0, b0, r0, e0;
    logic found;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    src_addr = '0; dst_addr = '0; len = '0;
    repeat (3) tick();
    chk("rst_req", 32'(dma_req), 32'd0);
    chk("rst_rnw", 32'(dma_rnw), 32'd1);
    chk("rst_addr", 32'(dma_addr), 32'd0);
    chk("rst_wd", 32'(dma_wd), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_aborted", 32'(aborted), 32'd0);
    rst_n = 1'b1;
    tick(); tick();

    ack_delay = 1; end_lat = 2;
    run_copy(22'h000100, 22'h200000, 16'd6, "basic");

    ack_delay = 0; end_lat = 1;
    run_copy(22'h3FFFFE, 22'h001000, 16'd4, "wrap");

    d0 = done_cnt; b0 = busy_cyc; r0 = req_cyc;
    pulse_start(22'h000050, 22'h000060, 16'd0);
    chk("len0_busy", 32'(busy), 32'd1);
    chk("len0_done", 32'(done), 32'd1);
    tick();
    chk("len0_busy_drop", 32'(busy), 32'd0);
    chk("len0_done_drop", 32'(done), 32'd0);
    tick();
    chk("len0_done_pulses", 32'(done_cnt - d0), 32'd1);
    chk("len0_busy_cycles", 32'(busy_cyc - b0), 32'd1);
    chk("len0_req_cycles", 32'(req_cyc - r0), 32'd0);

    ack_delay = 5; end_lat = 3;
    r0 = req_cyc;
    run_copy(22'h00ABC0, 22'h100000, 16'd5, "stall");
    chk("stall_req_cycles", 32'(req_cyc - r0), 32'd60);

    ack_delay = 1; end_lat = 2;
    d0 = done_cnt; a0 = abort_cnt;
    push_copy(22'h010000, 22'h020000, 16'd7);
    pulse_start(22'h010000, 22'h020000, 16'd7);
    tick(); tick();
    pulse_start(22'h0ABCDE, 22'h0FFFF0, 16'd3);
    chk("busy_start_still_busy", 32'(busy), 32'd1);
    wait_end(d0, a0, "busy_start");
    chk("busy_start_done_pulses", 32'(done_cnt - d0), 32'd1);
    chk("busy_start_all_issued", 32'(exp_q.size()), 32'd0);

    ack_delay = 1; end_lat = 5;
    d0 = done_cnt; a0 = abort_cnt;
    push_copy(22'h000400, 22'h300000, 16'd8);
    pulse_start(22'h000400, 22'h300000, 16'd8);
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (pend_wr() == 2 && dma_req && !dma_ack && !dma_rnw) begin found = 1'b1; break; end
    end
    chk("abort_trigger_found", 32'(found), 32'd1);
    e0 = end_cnt;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (abort_cnt != a0) begin found = 1'b1; break; end
      chk("abort_no_new_req", 32'(dma_req), 32'd0);
      tick();
    end
    chk("aborted_seen", 32'(found), 32'd1);
    chk("aborted_after_two_ends", 32'(ends_at_abort - e0), 32'd2);
    tick();
    chk("abort_single_pulse", 32'(abort_cnt - a0), 32'd1);
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
    chk("abort_idle", 32'(busy), 32'd0);
    exp_q.delete();
    run_copy(22'h000500, 22'h300100, 16'd3, "after_abort");

    ack_delay = 0; end_lat = 4;
    push_copy(22'h001000, 22'h002000, 16'd8);
    pulse_start(22'h001000, 22'h002000, 16'd8);
    tick(); tick();
    chk("mid_rd_req", 32'(dma_req & dma_rnw), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_req_drop", 32'(dma_req), 32'd0);
    chk("rst_mid_busy_drop", 32'(busy), 32'd0);
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (pend.size() == 0) begin found = 1'b1; break; end
    end
    chk("late_ends_drained", 32'(found), 32'd1);
    chk("late_ends_idle", 32'(busy), 32'd0);
    run_copy(22'h001000, 22'h002000, 16'd5, "after_reset");

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dma_block_copier.md
DMA_BLOCK_COPIER -- requirements
Module: dma_block_copier

Interface
REQ-001 The block SHALL have these ports, one per line: name  direction  width  meaning.
  clk  in  1  clock; all state changes on rising edge.
  rst_n  in  1  reset, asynchronous, active-low.
  start  in  1  one-cycle pulse; launches a copy using src_addr, dst_addr and len.
  abort  in  1  level; stops the copy in progress.
  src_addr  in  22  first source byte address; sampled on accepted start.
  dst_addr  in  22  first destination byte address; sampled on accepted start.
  len  in  16  byte count; sampled on accepted start; 0 = empty copy.
  busy  out  1  high from the cycle after accepted start until the copy ends.
  done  out  1  one-cycle pulse on normal completion.
  aborted  out  1  one-cycle pulse on abort completion.
  dma_req  out  1  request to one DMA sequencer input port.
  dma_addr  out  22  request address.
  dma_rnw  out  1  1 = read, 0 = write.
  dma_wd  out  8  write data.
  dma_ack  in  1  request accepted; addr/rnw/wd captured this cycle.
  dma_end  in  1  oldest outstanding access complete; dma_rd valid for reads.
  dma_rd  in  8  read data.
REQ-002 The block SHALL have no parameters.

Function
REQ-003 Handshake: the block SHALL hold dma_req, dma_addr, dma_rnw and dma_wd stable while dma_req=1 and dma_ack=0.
REQ-004 Handshake: in a dma_ack cycle the block MAY present a new request in the next cycle without deasserting dma_req.
REQ-005 Handshake: the block SHALL count dma_end pulses in order against acks, with outstanding = acks - ends, range 0..4.
REQ-006 The block SHALL contain a 4-entry byte FIFO and the states IDLE, RD, WR.
REQ-007 IDLE: start=1 SHALL load the source pointer, destination pointer, rd_left=len and wr_left=len.
REQ-008 IDLE: on start with len!=0, the block SHALL go to RD; on start with len=0, it SHALL pulse done in the next cycle and issue no request.
REQ-009 RD: dma_req=1 and dma_rnw=1 SHALL hold while phase_issued<4, rd_left!=0 and abort=0.
REQ-010 RD: dma_addr SHALL equal the source pointer.
REQ-011 RD: each ack SHALL increment the source pointer modulo 2^22, decrement rd_left and increment phase_issued.
REQ-012 RD: each dma_end SHALL push dma_rd into the FIFO.
REQ-013 RD to WR SHALL occur when (phase_issued=4 or rd_left=0) and outstanding=0, including end-of-cycle decrements; phase_issued SHALL clear on entering RD.
REQ-014 WR: dma_req=1 and dma_rnw=0 SHALL hold while the FIFO is non-empty and abort=0.
REQ-015 WR: dma_addr SHALL equal the destination pointer and dma_wd SHALL equal the FIFO head.
REQ-016 WR: each ack SHALL pop the FIFO, increment the destination pointer modulo 2^22 and decrement wr_left.
REQ-017 WR exit SHALL require an empty FIFO and outstanding=0; the block SHALL then go to RD if wr_left!=0, else to IDLE with a done pulse.
REQ-018 Simultaneous dma_ack and dma_end in one cycle SHALL leave outstanding unchanged.
REQ-019 The FIFO SHALL never overflow, because reserved slots never exceed 4 per phase.
REQ-020 start SHALL be ignored while busy=1.
REQ-021 Abort: abort=1 SHALL stop new requests from the next cycle onward; a request acked in the same cycle SHALL still count.
REQ-022 Abort completion: after outstanding reaches 0, the block SHALL flush the FIFO, go to IDLE and pulse aborted, not done.
REQ-023 In IDLE, dma_req SHALL be 0, dma_rnw SHALL be 1, and dma_addr and dma_wd SHALL be don't-care.
REQ-024 busy SHALL equal (state != IDLE).

Reset
REQ-025 On rst_n=0 the block SHALL asynchronously enter IDLE.
REQ-026 On rst_n=0 the block SHALL clear the pointers, counters, FIFO and outstanding count.
REQ-027 During reset: dma_req=0, dma_rnw=1, dma_addr=0, dma_wd=0, busy=0, done=0 and aborted=0.
REQ-028 Reset mid-copy SHALL drop dma_req immediately; late dma_end pulses after reset SHALL be ignored while outstanding=0.

Verification
REQ-029 Scenario: start with src=0x000100, dst=0x200000, len=6, ack the cycle after each req, end 2 cycles after ack -> reads 0x100..0x103, writes 0x200000..0x200003, reads 0x104..0x105, writes 0x200004..0x200005, data preserved, one done pulse.
REQ-030 Scenario: start with src=0x3FFFFE, len=4 -> read addresses 0x3FFFFE, 0x3FFFFF, 0x000000, 0x000001.
REQ-031 Scenario: start with len=0 -> done the cycle after start, dma_req stays 0, busy high exactly 1 cycle.
REQ-032 Scenario: ack withheld 5 cycles -> dma_req, dma_addr and dma_rnw stable for all 5 cycles; ack and end in the same cycle -> outstanding count unchanged.
REQ-033 Scenario: abort asserted in WR with 2 writes outstanding -> no new req, aborted pulses after the 2nd end, then a new start is accepted.
REQ-034 Scenario: start pulsed while busy -> ignored; rst_n pulsed low mid-RD -> dma_req=0 asynchronously and busy=0.
